plic_irq_gateway: RTL and testbench
===================================

# plic_irq_gateway

Per-source interrupt gateway for the custom RV PLIC. It sits directly downstream of the per-source two-flop synchronizers and consumes their already-synchronized `src_i` outputs. Each source is converted into a pending bit `ip_o` for the priority/target logic, using level or edge semantics. The claim/complete handshake keeps at most one request per source in flight. Edges arriving while a request is in flight are counted so none are lost.

## Interface
- `N_SOURCE`, default 32: number of interrupt sources.
- `CNT_WIDTH`, default 4: width of the per-source queued-edge counter; must be ≥ 1.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `src_i` in `N_SOURCE`: synchronized interrupt sources.
- `le_i` in `N_SOURCE`: 1 = edge-triggered, 0 = level-triggered; quasi-static.
- `claim_i` in `N_SOURCE`: single-cycle claim strobe per source.
- `complete_i` in `N_SOURCE`: single-cycle completion strobe per source.
- `ovf_clr_i` in `N_SOURCE`: clears the sticky overflow flag.
- `ip_o` out `N_SOURCE`: pending; registered.
- `ia_o` out `N_SOURCE`: active, meaning a request is pending or in service; registered.
- `ovf_o` out `N_SOURCE`: sticky queued-edge overflow; registered.

## Operation
- All sources are independent. Everything below applies per source `i`.
- **Sampling register:** `src_q` is a register of `src_i`, reset to 0.
- **Event definition:**
  - `evt = src_i & ~src_q` when `le_i = 1`.
  - `evt = src_i` when `le_i = 0`.
- **States** (encoded by `ip`/`ia`):
  - IDLE: `ip = 0`, `ia = 0`.
  - PENDING: `ip = 1`, `ia = 1`.
  - CLAIMED: `ip = 0`, `ia = 1`.
- **Transitions:**
  - IDLE: `evt` → PENDING. The event is not counted.
  - PENDING: `claim_i` → CLAIMED. `complete_i` is ignored. If claim and complete arrive together, only the claim takes effect.
  - CLAIMED, on `complete_i`:
    - Edge mode with `cnt + evt > 0` → PENDING, with `cnt_next = cnt + evt - 1`.
    - Otherwise → IDLE.
  - CLAIMED: `claim_i` is ignored.
  - IDLE: `claim_i` and `complete_i` are ignored.
- **Edge counting** (edge mode only):
  - An `evt` in PENDING, or in CLAIMED without a same-cycle complete, increments `cnt`.
  - `cnt` saturates at `2^CNT_WIDTH - 1`.
  - An increment attempted at saturation sets `ovf`.
- **Level mode:**
  - `cnt` is held at 0 and never increments; `ovf` never sets.
  - After complete the source returns to IDLE. If `src_i` is still high, it re-enters PENDING on the next edge.
- **Overflow clear:** `ovf_clr_i` clears `ovf`. If a set and a clear hit the same cycle, the set wins.
- **Changing `le_i`:** software changes `le_i` only while the source is IDLE. Changing it elsewhere is legal but only guarantees that `cnt` is forced to 0 while `le_i = 0`.
- **Reset:** all `ip_o`, `ia_o`, `ovf_o`, `cnt` and `src_q` go to 0, and every state goes to IDLE. A source already high at reset release produces one edge event on the first clock.

## Timing
- **Event latency:** an event sampled at rising edge `t` gives `ip_o = 1` and `ia_o = 1` from edge `t`, i.e. visible in cycle `t+1`. There is no combinational path from inputs to outputs.
- **Claim:** a claim sampled at edge `t` drops `ip_o` in cycle `t+1`.
- **Complete with queued edge:** a complete at edge `t` that re-arms gives `ip_o = 1` in cycle `t+1`, with no IDLE cycle in between.
- **Complete to IDLE:** `ia_o` drops in cycle `t+1`.
- **Back-to-back handshakes:** accepted every cycle. Claim and complete may be asserted on consecutive cycles.
- **Reset mid-operation:** asynchronous clear of all state. The first event after `rst_ni` rises is evaluated on the first clock edge.

## Test plan
- **Edge, single:** `le = 1`, pulse `src` 0→1 at cycle 5 → `ip = 1` at cycle 6. Claim at 8 → `ip = 0` at 9, `ia = 1`. Complete at 10 → `ia = 0` at 11.
- **Edge, queued:** 3 edges while CLAIMED → `cnt = 3`. Each complete re-arms `ip` the next cycle. After the third claim/complete pair → IDLE, `ia = 0`.
- **Overflow** (`CNT_WIDTH = 2`): 4 edges while CLAIMED → `cnt = 3`, `ovf = 1`. Same-cycle `ovf_clr` with a further edge → `ovf` stays 1. Later `ovf_clr` alone → `ovf = 0`.
- **Level:** `le = 0`, hold `src` high → `ip = 1`. Claim, then complete with `src` still high → `ia = 0` for one cycle, then `ip = 1` again. Drop `src` before complete → remains IDLE.
- **Simultaneous strobes:** claim+complete in PENDING → CLAIMED. Edge+complete in CLAIMED with `cnt = 0` → PENDING, `cnt = 0`. Claim in IDLE → no change.
- **Reset:** assert `rst_ni` low mid-CLAIMED with `cnt = 2` → all outputs 0 immediately. Release with `src` high in edge mode → `ip = 1` one cycle after the first clock.

Source files
------------

// File: rtl/plic_irq_gateway.sv
// ============================================================================
// Module      : plic_irq_gateway
// Description : Per-source PLIC interrupt gateway. It turns synchronized
//               sources into pending/active bits and queues edges that arrive
//               while a request is in flight.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module plic_irq_gateway #(
    parameter int N_SOURCE  = 32,
    parameter int CNT_WIDTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N_SOURCE-1:0] src_i,
    input  logic [N_SOURCE-1:0] le_i,
    input  logic [N_SOURCE-1:0] claim_i,
    input  logic [N_SOURCE-1:0] complete_i,
    input  logic [N_SOURCE-1:0] ovf_clr_i,
    output logic [N_SOURCE-1:0] ip_o,
    output logic [N_SOURCE-1:0] ia_o,
    output logic [N_SOURCE-1:0] ovf_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    // State bit 1 is the pending flag and bit 0 the active flag.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CLAIMED = 2'b01,
        ST_PENDING = 2'b11
    } state_e;

    genvar i;
    generate
        for (i = 0; i < N_SOURCE; i++) begin : g_src
            state_e               state_q, state_d;
            logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
            logic                 ovf_q, ovf_d;
            logic                 src_q;
            logic                 evt;
            logic                 inc;
            logic                 set_ovf;

            always_comb begin
                evt     = le_i[i] ? (src_i[i] & ~src_q) : src_i[i];
                state_d = state_q;
                cnt_d   = cnt_q;
                inc     = 1'b0;
                set_ovf = 1'b0;

                case (state_q)
                    ST_IDLE: begin
                        if (evt) begin
                            state_d = ST_PENDING;
                        end
                    end
                    ST_PENDING: begin
                        inc = le_i[i] & evt;
                        if (claim_i[i]) begin
                            state_d = ST_CLAIMED;
                        end
                    end
                    ST_CLAIMED: begin
                        if (complete_i[i]) begin
                            // Re-arm directly from the queue; a same-cycle edge
                            // is consumed by the re-arm instead of being counted.
                            if (le_i[i] && (evt || (cnt_q != '0))) begin
                                state_d = ST_PENDING;
                                if (!evt) begin
                                    cnt_d = cnt_q - CNT_ONE;
                                end
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            inc = le_i[i] & evt;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase

                if (inc) begin
                    if (cnt_q == CNT_MAX) begin
                        set_ovf = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                if (!le_i[i]) begin
                    cnt_d = '0;
                end

                ovf_d = set_ovf | (ovf_q & ~ovf_clr_i[i]);
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    ovf_q   <= 1'b0;
                    src_q   <= 1'b0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    ovf_q   <= ovf_d;
                    src_q   <= src_i[i];
                end
            end

            assign ip_o[i]  = state_q[1];
            assign ia_o[i]  = state_q[0];
            assign ovf_o[i] = ovf_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_plic_irq_gateway.sv
// ============================================================================
// Module      : tb_plic_irq_gateway
// Description : Directed self-checking bench for plic_irq_gateway.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_plic_irq_gateway;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] src, le, claim, complete, ovf_clr;
    logic [N-1:0] ip, ia, ovf;

    int passes = 0;
    int total  = 0;

    plic_irq_gateway #(
        .N_SOURCE  (N),
        .CNT_WIDTH (2)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .src_i      (src),
        .le_i       (le),
        .claim_i    (claim),
        .complete_i (complete),
        .ovf_clr_i  (ovf_clr),
        .ip_o       (ip),
        .ia_o       (ia),
        .ovf_o      (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    initial begin
        rst_n = 1'b0; src = '0; le = 4'b1101; claim = '0; complete = '0; ovf_clr = '0;
        tick(); tick();
        check("reset_ip", ip, 4'b0000);
        check("reset_ia", ia, 4'b0000);
        check("reset_ovf", ovf, 4'b0000);
        rst_n = 1'b1;
        tick();

        // Edge, single (source 0)
        src[0] = 1; tick();
        check("edge_ip", ip, 4'b0001);
        check("edge_ia", ia, 4'b0001);
        src[0] = 0; tick();
        claim[0] = 1; tick(); claim[0] = 0;
        check("claim_ip", ip, 4'b0000);
        check("claim_ia", ia, 4'b0001);
        complete[0] = 1; tick(); complete[0] = 0;
        check("complete_ia", ia, 4'b0000);

        // Edge, queued: three edges while claimed
        src[0] = 1; tick(); src[0] = 0; tick();
        claim[0] = 1; tick(); claim[0] = 0;
        for (int k = 0; k < 3; k++) begin
            src[0] = 1; tick(); src[0] = 0; tick();
        end
        check("queued_ip_claimed", ip, 4'b0000);
        check("queued_no_ovf", ovf, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            complete[0] = 1; tick(); complete[0] = 0;
            check("queued_rearm_ip", ip, 4'b0001);
            claim[0] = 1; tick(); claim[0] = 0;
            check("queued_claim_ip", ip, 4'b0000);
        end
        complete[0] = 1; tick(); complete[0] = 0;
        check("queued_idle_ia", ia, 4'b0000);

        // Overflow with a 2-bit counter
        src[0] = 1; tick(); src[0] = 0; tick();
        claim[0] = 1; tick(); claim[0] = 0;
        for (int k = 0; k < 3; k++) begin
            src[0] = 1; tick(); src[0] = 0; tick();
        end
        check("ovf_at_sat", ovf, 4'b0000);
        src[0] = 1; tick(); src[0] = 0; tick();
        check("ovf_set", ovf, 4'b0001);
        src[0] = 1; ovf_clr[0] = 1; tick(); src[0] = 0; ovf_clr[0] = 0;
        check("ovf_set_wins", ovf, 4'b0001);
        tick();
        ovf_clr[0] = 1; tick(); ovf_clr[0] = 0;
        check("ovf_cleared", ovf, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            complete[0] = 1; tick(); complete[0] = 0;
            check("ovf_drain_ip", ip, 4'b0001);
            claim[0] = 1; tick(); claim[0] = 0;
        end
        complete[0] = 1; tick(); complete[0] = 0;
        check("ovf_drain_ia", ia, 4'b0000);

        // Level mode (source 1)
        src[1] = 1; tick();
        check("level_ip", ip, 4'b0010);
        claim[1] = 1; tick(); claim[1] = 0;
        check("level_claim_ia", ia, 4'b0010);
        complete[1] = 1; tick(); complete[1] = 0;
        check("level_gap_ia", ia, 4'b0000);
        tick();
        check("level_repend_ip", ip, 4'b0010);
        claim[1] = 1; tick(); claim[1] = 0;
        src[1] = 0; tick();
        complete[1] = 1; tick(); complete[1] = 0;
        tick();
        check("level_stay_idle", ia, 4'b0000);

        // Simultaneous strobes (source 2)
        src[2] = 1; tick(); src[2] = 0; tick();
        claim[2] = 1; complete[2] = 1; tick(); claim[2] = 0; complete[2] = 0;
        check("sim_claim_ip", ip, 4'b0000);
        check("sim_claim_ia", ia, 4'b0100);
        src[2] = 1; complete[2] = 1; tick(); src[2] = 0; complete[2] = 0;
        check("sim_evt_cpl_ip", ip, 4'b0100);
        claim[2] = 1; tick(); claim[2] = 0;
        complete[2] = 1; tick(); complete[2] = 0;
        check("sim_cnt_zero_ia", ia, 4'b0000);
        claim[2] = 1; tick(); claim[2] = 0;
        check("idle_claim_ip", ip, 4'b0000);
        check("idle_claim_ia", ia, 4'b0000);

        // Reset mid-claimed with two queued edges
        src[0] = 1; tick(); src[0] = 0; tick();
        claim[0] = 1; tick(); claim[0] = 0;
        for (int k = 0; k < 2; k++) begin
            src[0] = 1; tick(); src[0] = 0; tick();
        end
        check("pre_rst_ia", ia, 4'b0001);
        src[0] = 1;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ia", ia, 4'b0000);
        check("async_rst_ip", ip, 4'b0000);
        tick();
        rst_n = 1'b1;
        #1;
        check("rel_ip_before_clk", ip, 4'b0000);
        tick();
        check("rel_first_edge_ip", ip, 4'b0001);
        src[0] = 0;
        tick();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

`default_nettype wire
